// File: rtl/stepper_pkg.sv
// Shared types and constants for stepper motion control channels.
package stepper_pkg;

  // Move sequencer states.
  //   state  | meaning
  //   IDLE   | waiting for a move command (cmd_ready asserted)
  //   ACCEL  | stepping with a shrinking interval toward the target period
  //   CRUISE | stepping at the target period
  //   DECEL  | stepping with a growing interval back toward START_PERIOD
  //   DONE   | single-cycle completion pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    DONE
  } state_e;

  // One-hot coil drive patterns, in forward rotation order.
  localparam logic [3:0] PH_A        = 4'b0001;
  localparam logic [3:0] PH_B        = 4'b0010;
  localparam logic [3:0] PH_C        = 4'b0100;
  localparam logic [3:0] PH_D        = 4'b1000;
  localparam logic [3:0] PHASE_RESET = PH_A;

  // Default sizing and motion profile.
  localparam int unsigned DEF_PER_W        = 24;
  localparam int unsigned DEF_STEPS_W      = 16;
  localparam int unsigned DEF_POS_W        = 24;
  localparam int unsigned DEF_START_PERIOD = 500000;
  localparam int unsigned DEF_MIN_PERIOD   = 50000;
  localparam int unsigned DEF_RAMP_DELTA   = 25000;

endpackage

// File: rtl/stepper_phase_seq.sv
// One-hot coil phase rotator for a 4-phase unipolar stepper.
module stepper_phase_seq
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  input  logic       dir_i,
  output logic [3:0] phase_o
);

  logic [3:0] phase_q;

  // Rotate left (forward) or right (reverse) by one position per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PHASE_RESET;
    end else if (step_i) begin
      phase_q <= dir_i ? {phase_q[2:0], phase_q[3]} : {phase_q[0], phase_q[3:1]};
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts a move command, runs a linear period ramp
// (accelerate / cruise / decelerate) with a per-step interval timer, tracks
// absolute position and supports a controlled abort.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned PER_W        = DEF_PER_W,
  parameter int unsigned STEPS_W      = DEF_STEPS_W,
  parameter int unsigned POS_W        = DEF_POS_W,
  parameter int unsigned START_PERIOD = DEF_START_PERIOD,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned RAMP_DELTA   = DEF_RAMP_DELTA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_dir_i,
  input  logic [STEPS_W-1:0] cmd_steps_i,
  input  logic [PER_W-1:0]   cmd_period_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               step_tick_o,
  output logic [3:0]         phase_o,
  output logic [POS_W-1:0]   position_o
);

  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W:0]   DELTA_X = (PER_W+1)'(RAMP_DELTA);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic [STEPS_W-1:0] ramp_q, ramp_d;
  logic [PER_W-1:0]   target_q, target_d;
  logic [PER_W-1:0]   cur_q, cur_d;
  logic [PER_W-1:0]   timer_q, timer_d;
  logic               fin_q, fin_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               cmd_ready_q, busy_q, done_q, tick_q;

  logic               running;
  logic               step_now;
  logic [PER_W-1:0]   cmd_target;
  logic [PER_W-1:0]   ramp_down;
  logic [PER_W:0]     up_x;
  logic [PER_W-1:0]   ramp_up;

  // fin_q marks "last action taken, enter DONE on the next edge"; the timer
  // and stepping are frozen while it is set.
  assign running  = ((state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL)) && !fin_q;
  assign step_now = running && (timer_q == PER_W'(1));

  assign cmd_target = (cmd_period_i < MIN_P) ? MIN_P : cmd_period_i;

  // Saturating period arithmetic, widened by one bit so nothing wraps.
  assign ramp_down = ({1'b0, cur_q} > ({1'b0, target_q} + DELTA_X))
                   ? (cur_q - DELTA_X[PER_W-1:0]) : target_q;
  assign up_x      = {1'b0, cur_q} + DELTA_X;
  assign ramp_up   = (up_x >= {1'b0, START_P}) ? START_P : up_x[PER_W-1:0];

  // Next-state and datapath decisions; step updates first, abort afterwards.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    ramp_d   = ramp_q;
    target_d = target_q;
    cur_d    = cur_q;
    timer_d  = timer_q;
    fin_d    = fin_q;
    pos_d    = pos_q;

    if (running) timer_d = timer_q - PER_W'(1);

    case (state_q)
      IDLE: begin
        if (fin_q) begin
          state_d = DONE;
          fin_d   = 1'b0;
        end else if (cmd_valid_i && cmd_ready_q) begin
          dir_d    = cmd_dir_i;
          rem_d    = cmd_steps_i;
          ramp_d   = '0;
          target_d = cmd_target;
          if (cmd_steps_i == '0) begin
            fin_d = 1'b1;
          end else if (cmd_target >= START_P) begin
            cur_d   = cmd_target;
            timer_d = cmd_target;
            state_d = CRUISE;
          end else begin
            cur_d   = START_P;
            timer_d = START_P;
            state_d = ACCEL;
          end
        end
      end

      DONE: state_d = IDLE;

      default: begin
        if (fin_q) begin
          state_d = DONE;
          fin_d   = 1'b0;
        end else begin
          if (step_now) begin
            rem_d = rem_q - STEPS_W'(1);
            pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
            case (state_q)
              ACCEL: begin
                ramp_d = ramp_q + STEPS_W'(1);
                if (rem_d != '0) begin
                  if (rem_d <= ramp_d) begin
                    state_d = DECEL;
                  end else begin
                    cur_d = ramp_down;
                    if (ramp_down == target_q) state_d = CRUISE;
                  end
                end
              end
              CRUISE: begin
                if ((rem_d != '0) && (rem_d <= ramp_q)) state_d = DECEL;
              end
              DECEL: begin
                ramp_d = (ramp_q == '0) ? '0 : (ramp_q - STEPS_W'(1));
                cur_d  = ramp_up;
              end
              default: ;
            endcase
            if (rem_d == '0) fin_d = 1'b1;
            timer_d = cur_d;
          end

          // Trim the remaining distance to what the ramp-down needs.
          if (abort_i && ((state_q == ACCEL) || (state_q == CRUISE)) && !fin_d) begin
            if (ramp_d < rem_d) rem_d = ramp_d;
            if (rem_d == '0) fin_d = 1'b1;
            else             state_d = DECEL;
          end
        end
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      rem_q       <= '0;
      ramp_q      <= '0;
      target_q    <= START_P;
      cur_q       <= START_P;
      timer_q     <= '0;
      fin_q       <= 1'b0;
      pos_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      rem_q       <= rem_d;
      ramp_q      <= ramp_d;
      target_q    <= target_d;
      cur_q       <= cur_d;
      timer_q     <= timer_d;
      fin_q       <= fin_d;
      pos_q       <= pos_d;
      cmd_ready_q <= (state_d == IDLE) && !fin_d;
      busy_q      <= (state_d == ACCEL) || (state_d == CRUISE) || (state_d == DECEL);
      done_q      <= (state_d == DONE);
      tick_q      <= step_now;
    end
  end

  stepper_phase_seq u_phase (
    .clk     (clk),
    .rst     (rst),
    .step_i  (step_now),
    .dir_i   (dir_q),
    .phase_o (phase_o)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign step_tick_o = tick_q;
  assign position_o  = pos_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl with a step-level motion model.
module tb_stepper_move_ctrl;

  localparam int START = 100;
  localparam int MINP  = 4;
  localparam int DELTA = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_dir = 1'b1;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        busy_o, done_o, step_tick_o;
  logic [3:0]  phase_o;
  logic [23:0] position_o;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [3:0]  ph;
    logic [23:0] pos;
  } ev_t;

  ev_t expq[$];
  ev_t mon_ev;
  bit  mon_ok;
  int  edge_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_ph = 0;
  int  m_pos = 0;

  stepper_move_ctrl #(
    .PER_W(24), .STEPS_W(16), .POS_W(24),
    .START_PERIOD(START), .MIN_PERIOD(MINP), .RAMP_DELTA(DELTA)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir),
    .cmd_steps_i(cmd_steps), .cmd_period_i(cmd_period), .abort_i(abort),
    .busy_o(busy_o), .done_o(done_o), .step_tick_o(step_tick_o),
    .phase_o(phase_o), .position_o(position_o)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_step(input int cyc, input bit dir);
    ev_t e;
    m_ph  = dir ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
    m_pos = dir ? m_pos + 1 : m_pos - 1;
    e.is_done = 1'b0;
    e.cyc = cyc;
    e.ph  = 4'(1 << m_ph);
    e.pos = m_pos[23:0];
    expq.push_back(e);
  endfunction

  function automatic void push_done(input int cyc);
    ev_t e;
    e.is_done = 1'b1;
    e.cyc = cyc;
    e.ph  = '0;
    e.pos = '0;
    expq.push_back(e);
  endfunction

  // Step-level model: mode 0 accel, 1 cruise, 2 decel; times relative to accept.
  // ab = 0 means no abort, otherwise abort held from edge acc+ab onward.
  function automatic void model_cmd(input bit dir, input int steps, input int per,
                                    input int ab, input int acc);
    int target, cur, ramp, rem, mode, t, tprev, e, mode_at_step;
    target = (per < MINP) ? MINP : per;
    if (steps == 0) begin
      push_done(acc + 1);
      return;
    end
    rem = steps; ramp = 0; tprev = 0;
    mode = (target >= START) ? 1 : 0;
    cur  = (target >= START) ? target : START;
    forever begin
      t = tprev + cur;
      if (ab > 0 && mode != 2) begin
        e = (ab > tprev + 1) ? ab : tprev + 1;
        if (e < t) begin
          if (ramp < rem) rem = ramp;
          if (rem == 0) begin
            push_done(acc + e + 1);
            return;
          end
          mode = 2;
        end
      end
      mode_at_step = mode;
      rem--;
      push_step(acc + t, dir);
      if (mode == 0) begin
        ramp++;
        if (rem != 0 && rem <= ramp) mode = 2;
        else if (rem != 0) begin
          cur = (cur - DELTA > target) ? cur - DELTA : target;
          if (cur == target) mode = 1;
        end
      end else if (mode == 1) begin
        if (rem != 0 && rem <= ramp) mode = 2;
      end else begin
        ramp = (ramp > 0) ? ramp - 1 : 0;
        cur  = (cur + DELTA < START) ? cur + DELTA : START;
      end
      if (rem == 0) begin
        push_done(acc + t + 1);
        return;
      end
      if (ab > 0 && mode_at_step != 2 && ab <= t) begin
        if (ramp < rem) rem = ramp;
        if (rem == 0) begin
          push_done(acc + t + 1);
          return;
        end
        mode = 2;
      end
      tprev = t;
    end
  endfunction

  // Monitor: every step/done presented by the DUT is matched against the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && (step_tick_o === 1'b1 || done_o === 1'b1)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d tick=%b done=%b, nothing expected",
                 edge_cnt, step_tick_o, done_o);
      end else begin
        mon_ev = expq.pop_front();
        if (mon_ev.is_done)
          mon_ok = done_o && !step_tick_o && !busy_o && (edge_cnt == mon_ev.cyc);
        else
          mon_ok = step_tick_o && !done_o && busy_o && (edge_cnt == mon_ev.cyc) &&
                   (phase_o == mon_ev.ph) && (position_o == mon_ev.pos);
        if (!mon_ok) begin
          errors++;
          $display("FAIL %s_event: got cycle %0d tick=%b done=%b busy=%b phase=%b pos=%0d, expected cycle %0d phase=%b pos=%0d",
                   mon_ev.is_done ? "done" : "step", edge_cnt, step_tick_o, done_o, busy_o,
                   phase_o, $signed(position_o), mon_ev.cyc, mon_ev.ph, $signed(mon_ev.pos));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_busy"},      32'(busy_o),      32'd0);
    chk({tag, "_done"},      32'(done_o),      32'd0);
    chk({tag, "_step_tick"}, 32'(step_tick_o), 32'd0);
    chk({tag, "_phase"},     32'(phase_o),     32'd1);
    chk({tag, "_position"},  32'(position_o),  32'd0);
  endtask

  task automatic start_cmd(input bit dir, input int steps, input int per, input int ab,
                           output int acc);
    int n;
    n = 0;
    acc = -1;
    while (cmd_ready_o !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      chk("ready_wait_timeout", 32'(cmd_ready_o), 32'd1);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = steps[15:0];
    cmd_period = per[23:0];
    @(negedge clk);
    acc = edge_cnt;
    cmd_valid = 1'b0;
    model_cmd(dir, steps, per, ab, acc);
  endtask

  task automatic run_cmd(input bit dir, input int steps, input int per, input int ab);
    int acc, n;
    start_cmd(dir, steps, per, ab, acc);
    if (acc < 0) return;
    if (ab > 0) begin
      while (edge_cnt < acc + ab - 1) @(negedge clk);
      abort = 1'b1;
    end
    n = 0;
    while (expq.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      chk("move_timeout_pending_events", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    abort = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 32'(cmd_ready_o), 32'd1);
    chk("busy_after_done",  32'(busy_o),      32'd0);
  endtask

  initial begin
    int acc, dir, steps, per, ab;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    run_cmd(1'b1, 5, 40, 0);      // ramp up then straight into decel
    run_cmd(1'b0, 8, 60, 0);      // full accel / cruise / decel, reverse
    chk("pos_after_reverse", 32'(position_o), 32'hFFFFFD);
    run_cmd(1'b1, 3, 150, 0);     // target slower than start: no ramp
    run_cmd(1'b1, 0, 40, 0);      // zero-length move
    run_cmd(1'b1, 20, 40, 250);   // abort in cruise
    run_cmd(1'b1, 20, 1, 0);      // period clamps to MIN
    run_cmd(1'b0, 10, 30, 1);     // abort before the first step

    for (int i = 0; i < 12; i++) begin
      dir   = int'($urandom_range(0, 1));
      steps = int'($urandom_range(0, 12));
      per   = int'($urandom_range(1, 200));
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 600)) : 0;
      run_cmd(dir[0], steps, per, ab);
    end

    // Reset in the middle of a cruise move: immediate reset values, no done.
    start_cmd(1'b1, 10, 150, 0, acc);
    while (acc >= 0 && edge_cnt < acc + 200) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_move_reset");
    expq.delete();
    m_ph = 0;
    m_pos = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("held_reset");
    #2 rst = 1'b0;
    @(negedge clk);
    run_cmd(1'b1, 3, 150, 0);
    chk("pos_after_reset_move", 32'(position_o), 32'd3);

    repeat (20) @(negedge clk);
    chk("no_trailing_events", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
